// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Operand forwarding and RAW hazard control for a 5-stage in-order pipeline.
//   It keeps its own shadow copy of the EX/MEM/WB destination information.
//   From that copy it computes the registered bypass selects for the next EX
//   instruction. It also runs a small IDLE/STALL FSM that holds the ID stage
//   while a hazard cannot be bypassed.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   isForw_ON                    1 = bypass enabled, 0 = stall on every RAW hazard
//   flush                        taken branch/jump, kills the ID instruction
//   id_valid/regwrite/isload     ID-stage instruction attributes
//   id_op, id_rs1, id_rs2, id_rd ID-stage opcode and register fields
//   data1, data2, s_data         EX-stage register-file operands and store data
//   exmem_result, memwb_result   bypass sources
//   stall                        hold PC and IF/ID (combinational)
//   ex_bubble                    EX holds a bubble this cycle (registered)
//   forwA, forwB                 bypass selects of the EX instruction (registered)
//   operand1, operand2, sData    bypassed EX operands (combinational)
//   stall_cnt                    saturating count of stall cycles since reset
module fwd_hazard_unit #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              isForw_ON,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              id_regwrite,
  input  logic              id_isload,
  input  logic [6:0]        id_op,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] s_data,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              stall,
  output logic              ex_bubble,
  output logic [1:0]        forwA,
  output logic [1:0]        forwB,
  output logic [DATA_W-1:0] operand1,
  output logic [DATA_W-1:0] operand2,
  output logic [DATA_W-1:0] sData,
  output logic [15:0]       stall_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              isload;
    logic [REG_AW-1:0] rd;
    logic [6:0]        op;
  } shadow_t;

  // index 0 = EX, 1 = MEM, 2 = WB
  shadow_t     r_shadow [0:2];
  logic [0:0]  r_state;
  logic [1:0]  r_cnt;
  logic [1:0]  r_forwA;
  logic [1:0]  r_forwB;
  logic        r_ex_bubble;
  logic [15:0] r_stall_cnt;

  logic       w_use_rs1, w_use_rs2;
  logic       w_ex_a, w_ex_b, w_mem_a, w_mem_b;
  logic       w_hazard, w_issue;
  logic [1:0] w_fwd_a, w_fwd_b;

  function automatic logic f_match(input shadow_t e, input logic [REG_AW-1:0] src);
    return e.valid && e.regwrite && (e.rd != '0) && (e.rd == src);
  endfunction

  function automatic logic [DATA_W-1:0] f_sel(input logic [1:0] sel,
                                               input logic [DATA_W-1:0] base);
    case (sel)
      2'b00:   return base;
      2'b01:   return exmem_result;
      2'b10:   return memwb_result;
      default: return '0;
    endcase
  endfunction

  // Which ID fields are real sources: rs1 is unused only by LUI/AUIPC/JAL,
  // rs2 is read only by register-register, store and branch formats.
  assign w_use_rs1 = !((id_op == OP_LUI) || (id_op == OP_AUIPC) || (id_op == OP_JAL));
  assign w_use_rs2 = (id_op == OP_R) || (id_op == OP_S) || (id_op == OP_B);

  assign w_ex_a  = w_use_rs1 && f_match(r_shadow[0], id_rs1);
  assign w_ex_b  = w_use_rs2 && f_match(r_shadow[0], id_rs2);
  assign w_mem_a = w_use_rs1 && f_match(r_shadow[1], id_rs1);
  assign w_mem_b = w_use_rs2 && f_match(r_shadow[1], id_rs2);

  // With bypassing only a load still in EX cannot be covered; without it any
  // in-flight producer in EX or MEM must drain. WB never conflicts because the
  // register file writes before it is read.
  assign w_hazard = id_valid && !flush &&
                    (isForw_ON ? (r_shadow[0].isload && (w_ex_a || w_ex_b))
                               : (w_ex_a || w_ex_b || w_mem_a || w_mem_b));

  // In STALL the countdown keeps the stall alive even once the hazard clears.
  always_comb begin
    stall = 1'b0;
    if (!rst && !flush) begin
      stall = w_hazard || ((r_state == ST_STALL) && (r_cnt != 2'd0));
    end
  end

  assign w_issue = id_valid && !stall && !flush;

  // EX match wins over MEM: it holds the younger value of the register.
  assign w_fwd_a = !isForw_ON ? 2'b00 : w_ex_a ? 2'b01 : w_mem_a ? 2'b10 : 2'b00;
  assign w_fwd_b = !isForw_ON ? 2'b00 : w_ex_b ? 2'b01 : w_mem_b ? 2'b10 : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_shadow[i] <= '0;
      end
      r_forwA     <= 2'b00;
      r_forwB     <= 2'b00;
      r_ex_bubble <= 1'b1;
    end else begin
      r_shadow[2] <= r_shadow[1];
      r_shadow[1] <= r_shadow[0];
      if (w_issue) begin
        r_shadow[0] <= '{valid: 1'b1, regwrite: id_regwrite, isload: id_isload,
                         rd: id_rd, op: id_op};
        r_forwA     <= w_fwd_a;
        r_forwB     <= w_fwd_b;
      end else begin
        r_shadow[0] <= '0;
        r_forwA     <= 2'b00;
        r_forwB     <= 2'b00;
      end
      r_ex_bubble <= !w_issue;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hazard) begin
            r_state <= ST_STALL;
            r_cnt   <= 2'(LOAD_LAT - 1);
          end
        end
        default: begin
          if ((r_cnt == 2'd0) && !w_hazard) begin
            r_state <= ST_IDLE;
          end else if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // forwB only matters for formats that actually read rs2 in EX: it steers
  // the ALU operand for R/B types and the store data for S type.
  always_comb begin
    operand2 = data2;
    sData    = s_data;
    if ((r_shadow[0].op == OP_R) || (r_shadow[0].op == OP_B)) begin
      operand2 = f_sel(r_forwB, data2);
    end else if (r_shadow[0].op == OP_S) begin
      sData = f_sel(r_forwB, s_data);
    end
  end

  assign operand1  = f_sel(r_forwA, data1);
  assign forwA     = r_forwA;
  assign forwB     = r_forwB;
  assign ex_bubble = r_ex_bubble;
  assign stall_cnt = r_stall_cnt;

endmodule
